// File: rtl/ann_neuron_mac.sv
// rtl/ann_neuron_mac.sv - single-neuron signed 8x8 MAC with bias, rescale, ReLU and saturation
module ann_neuron_mac #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 20,
    parameter int SHIFT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [7:0] x_in,
    input  logic signed [7:0] w_in,
    input  logic              bias_load,
    input  logic signed [7:0] bias_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        y_out,
    output logic              busy
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        FINAL  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  count;
    logic signed [7:0]        bias;

    logic signed [15:0]       product;
    logic signed [ACC_W-1:0]  product_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  biased;
    logic signed [ACC_W-1:0]  scaled;
    logic        [7:0]        activation;

    assign product     = x_in * w_in;
    assign product_ext = {{(ACC_W-16){product[15]}}, product};

    // Bias is pre-scaled so that after the shift it lands in activation units.
    assign bias_ext    = {{(ACC_W-8){bias[7]}}, bias};
    assign biased      = acc + (bias_ext <<< SHIFT);
    assign scaled      = biased >>> SHIFT;

    always_comb begin
        activation = 8'd0;
        if (scaled[ACC_W-1])
            activation = 8'd0;
        else if (|scaled[ACC_W-2:7])
            activation = 8'd127;
        else
            activation = {1'b0, scaled[6:0]};
    end

    assign in_ready = (state == ACCUM);
    assign busy     = (state != ACCUM) || (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            bias      <= '0;
            out_valid <= 1'b0;
            y_out     <= 8'd0;
        end else begin
            // Bias update is independent of the state; FINAL reads the old value.
            if (bias_load)
                bias <= bias_in;

            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc + product_ext;
                        if (count == LAST) begin
                            count <= '0;
                            state <= FINAL;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                FINAL: begin
                    y_out     <= activation;
                    out_valid <= 1'b1;
                    state     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ann_neuron_mac.sv
// tb/tb_ann_neuron_mac.sv - directed self-checking bench for ann_neuron_mac
module tb_ann_neuron_mac;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] x_in;
    logic signed [7:0] w_in;
    logic              bias_load;
    logic signed [7:0] bias_in;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        y_out;
    logic              busy;

    int checks;
    int errors;

    ann_neuron_mac #(.N_INPUTS(4), .ACC_W(20), .SHIFT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .w_in      (w_in),
        .bias_load (bias_load),
        .bias_in   (bias_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [7:0] x, input logic signed [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            x_in     = x;
            w_in     = w;
            tick();
        end
        in_valid = 1'b0;
        x_in     = '0;
        w_in     = '0;
    endtask

    task automatic load_bias(input logic signed [7:0] b);
        bias_load = 1'b1;
        bias_in   = b;
        tick();
        bias_load = 1'b0;
        bias_in   = '0;
    endtask

    task automatic collect(output logic [7:0] y, output bit ok);
        ok = 1'b0;
        y  = 8'd0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                y  = y_out;
                break;
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] y;
        bit ok;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'($urandom);
            x_in      = 8'($urandom);
            w_in      = 8'($urandom);
            bias_load = 1'($urandom);
            bias_in   = 8'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (y_out !== 8'd0) begin errors++; $display("FAIL reset_y_out: got %0d want 0", y_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0; in_valid = 1'b0; x_in = '0; w_in = '0;
        bias_load = 1'b0; bias_in = '0; out_ready = 1'b0;
        send(8'sd16, 8'sd16, 3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_early_output: got %b want 0", out_valid); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_wait_in_ready: got %b want 1", in_ready); end
            tick();
        end
        send(8'sd16, 8'sd16, 1);
        collect(y, ok);
        checks++; if (!ok || y !== 8'd64) begin errors++; $display("FAIL reset_first_result: got %0d (valid seen %0d) want 64", y, ok); end
    endtask

    task automatic test_basic_mac();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; x_in = 8'sd16; w_in = 8'sd16;
            tick();
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_accum[%0d]: got %b want 1", i, busy); end
        end
        in_valid = 1'b0; x_in = '0; w_in = '0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_final_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_final_in_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b want 1", out_valid); end
        checks++; if (y_out !== 8'd64) begin errors++; $display("FAIL basic_y_out: got %0d want 64", y_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_output: got %b want 1", busy); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_handshake_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_handshake_in_ready: got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_handshake_busy: got %b want 0", busy); end
    endtask

    task automatic test_relu_saturation();
        logic signed [7:0] xs [3];
        logic signed [7:0] ws [3];
        logic [7:0]        exp_y [3];
        logic [7:0]        y;
        bit                ok;
        xs[0] = -8'sd16;  ws[0] = 8'sd16;   exp_y[0] = 8'd0;
        xs[1] = 8'sd127;  ws[1] = 8'sd127;  exp_y[1] = 8'd127;
        xs[2] = -8'sd128; ws[2] = -8'sd128; exp_y[2] = 8'd127;
        for (int i = 0; i < 3; i++) begin
            send(xs[i], ws[i], 4);
            collect(y, ok);
            checks++; if (!ok || y !== exp_y[i]) begin errors++; $display("FAIL relu_sat[%0d]: got %0d (valid seen %0d) want %0d", i, y, ok, exp_y[i]); end
        end
    endtask

    task automatic test_bias();
        logic [7:0] y;
        bit ok;
        load_bias(8'sd8);
        send(8'sd1, 8'sd1, 4);
        collect(y, ok);
        checks++; if (!ok || y !== 8'd8) begin errors++; $display("FAIL bias_pos: got %0d want 8", y); end
        load_bias(-8'sd1);
        send(8'sd1, 8'sd1, 4);
        collect(y, ok);
        checks++; if (!ok || y !== 8'd0) begin errors++; $display("FAIL bias_neg_floor: got %0d want 0", y); end
        load_bias(8'sd8);
        send(8'sd1, 8'sd1, 4);
        bias_load = 1'b1; bias_in = -8'sd8;
        tick();
        bias_load = 1'b0; bias_in = '0;
        checks++; if (out_valid !== 1'b1 || y_out !== 8'd8) begin errors++; $display("FAIL bias_final_old: got %0d valid %b want 8 valid 1", y_out, out_valid); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        send(8'sd16, 8'sd16, 4);
        collect(y, ok);
        checks++; if (!ok || y !== 8'd56) begin errors++; $display("FAIL bias_final_next: got %0d want 56", y); end
        load_bias(8'sd0);
    endtask

    task automatic test_back_pressure();
        logic [7:0] y;
        bit ok;
        send(8'sd16, 8'sd16, 4);
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; x_in = 8'sd100; w_in = 8'sd100;
            checks++; if (out_valid !== 1'b1 || y_out !== 8'd64) begin errors++; $display("FAIL bp_hold[%0d]: got %0d valid %b want 64 valid 1", i, y_out, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            tick();
        end
        in_valid = 1'b0; x_in = '0; w_in = '0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        send(8'sd2, 8'sd8, 4);
        collect(y, ok);
        checks++; if (!ok || y !== 8'd4) begin errors++; $display("FAIL bp_next_result: got %0d want 4", y); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] y;
        bit ok;
        load_bias(8'sd8);
        send(8'sd16, 8'sd16, 2);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        send(8'sd16, 8'sd16, 4);
        collect(y, ok);
        checks++; if (!ok || y !== 8'd64) begin errors++; $display("FAIL mid_reset_result: got %0d want 64", y); end
        send(8'sd16, 8'sd16, 4);
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL out_reset_pre: got %b want 1", out_valid); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL out_reset_valid: got %b want 0", out_valid); end
        checks++; if (y_out !== 8'd0) begin errors++; $display("FAIL out_reset_y_out: got %0d want 0", y_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL out_reset_in_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        checks = 0; errors = 0;
        clk = 1'b0; rst = 1'b1; in_valid = 1'b0; x_in = '0; w_in = '0;
        bias_load = 1'b0; bias_in = '0; out_ready = 1'b0;
        test_reset();
        test_basic_mac();
        test_relu_saturation();
        test_bias();
        test_back_pressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
